// File: rtl/axil_arb_2to1.sv
// Two-requester AXI4-lite arbiter: independent read and write FSMs share one master port.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed s0-first priority instead of round robin.
module axil_arb_2to1 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester 0
   input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
   input  logic [2:0]            s0_axil_awprot,
   input  logic                  s0_axil_awvalid,
   output logic                  s0_axil_awready,
   input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
   input  logic                  s0_axil_wvalid,
   output logic                  s0_axil_wready,
   output logic [1:0]            s0_axil_bresp,
   output logic                  s0_axil_bvalid,
   input  logic                  s0_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
   input  logic [2:0]            s0_axil_arprot,
   input  logic                  s0_axil_arvalid,
   output logic                  s0_axil_arready,
   output logic [DATA_WIDTH-1:0] s0_axil_rdata,
   output logic [1:0]            s0_axil_rresp,
   output logic                  s0_axil_rvalid,
   input  logic                  s0_axil_rready,
   // requester 1
   input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
   input  logic [2:0]            s1_axil_awprot,
   input  logic                  s1_axil_awvalid,
   output logic                  s1_axil_awready,
   input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
   input  logic                  s1_axil_wvalid,
   output logic                  s1_axil_wready,
   output logic [1:0]            s1_axil_bresp,
   output logic                  s1_axil_bvalid,
   input  logic                  s1_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
   input  logic [2:0]            s1_axil_arprot,
   input  logic                  s1_axil_arvalid,
   output logic                  s1_axil_arready,
   output logic [DATA_WIDTH-1:0] s1_axil_rdata,
   output logic [1:0]            s1_axil_rresp,
   output logic                  s1_axil_rvalid,
   input  logic                  s1_axil_rready,
   // shared master port
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic      wr_gnt, rd_gnt, wr_pick, rd_pick;
   logic      aw_done, w_done;
   logic      wr_req0, wr_req1, wr_req, rd_req;
   logic      wr_xfer, wr_resp, rd_addr, rd_data;
   logic      g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
   logic      aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic      aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;

   assign wr_req0 = s0_axil_awvalid | s0_axil_wvalid;
   assign wr_req1 = s1_axil_awvalid | s1_axil_wvalid;
   assign wr_req  = wr_req0 | wr_req1;
   assign rd_req  = s0_axil_arvalid | s1_axil_arvalid;

`ifdef AXIL_ARB_FIXED_PRIO_EN
   assign wr_pick = ~wr_req0;
   assign rd_pick = ~s0_axil_arvalid;
`else
   logic wr_last, rd_last;
   // on a tie the port that did not win last time goes next
   assign wr_pick = (wr_req0 & wr_req1) ? ~wr_last : wr_req1;
   assign rd_pick = (s0_axil_arvalid & s1_axil_arvalid) ? ~rd_last : s1_axil_arvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_last <= 1'b1;
         rd_last <= 1'b1;
      end else begin
         if (wr_state == WR_IDLE && wr_req) wr_last <= wr_pick;
         if (rd_state == RD_IDLE && rd_req) rd_last <= rd_pick;
      end
   end
`endif

   // ---------------- write path ----------------
   assign wr_xfer   = (wr_state == WR_XFER);
   assign wr_resp   = (wr_state == WR_RESP);
   assign g_awvalid = wr_gnt ? s1_axil_awvalid : s0_axil_awvalid;
   assign g_wvalid  = wr_gnt ? s1_axil_wvalid  : s0_axil_wvalid;
   assign g_bready  = wr_gnt ? s1_axil_bready  : s0_axil_bready;

   assign m_axil_awaddr  = wr_gnt ? s1_axil_awaddr : s0_axil_awaddr;
   assign m_axil_awprot  = wr_gnt ? s1_axil_awprot : s0_axil_awprot;
   assign m_axil_wdata   = wr_gnt ? s1_axil_wdata  : s0_axil_wdata;
   assign m_axil_wstrb   = wr_gnt ? s1_axil_wstrb  : s0_axil_wstrb;
   assign m_axil_awvalid = wr_xfer & g_awvalid & ~aw_done;
   assign m_axil_wvalid  = wr_xfer & g_wvalid & ~w_done;
   assign m_axil_bready  = wr_resp & g_bready;

   assign aw_rdy = wr_xfer & m_axil_awready & ~aw_done;
   assign w_rdy  = wr_xfer & m_axil_wready & ~w_done;
   assign b_vld  = wr_resp & m_axil_bvalid;
   assign s0_axil_awready = aw_rdy & ~wr_gnt;
   assign s1_axil_awready = aw_rdy & wr_gnt;
   assign s0_axil_wready  = w_rdy & ~wr_gnt;
   assign s1_axil_wready  = w_rdy & wr_gnt;
   assign s0_axil_bvalid  = b_vld & ~wr_gnt;
   assign s1_axil_bvalid  = b_vld & wr_gnt;
   assign s0_axil_bresp   = m_axil_bresp;
   assign s1_axil_bresp   = m_axil_bresp;

   assign aw_hs = m_axil_awvalid & m_axil_awready;
   assign w_hs  = m_axil_wvalid & m_axil_wready;
   assign b_hs  = m_axil_bvalid & m_axil_bready;

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: if (wr_req) wr_next = WR_XFER;
         WR_XFER: if ((aw_done | aw_hs) & (w_done | w_hs)) wr_next = WR_RESP;
         WR_RESP: if (b_hs) wr_next = WR_IDLE;
         default: wr_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state <= WR_IDLE;
         wr_gnt   <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         wr_state <= wr_next;
         if (wr_state == WR_IDLE && wr_req) wr_gnt <= wr_pick;
         if (wr_next == WR_IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
      end
   end

   // ---------------- read path ----------------
   assign rd_addr   = (rd_state == RD_ADDR);
   assign rd_data   = (rd_state == RD_DATA);
   assign g_arvalid = rd_gnt ? s1_axil_arvalid : s0_axil_arvalid;
   assign g_rready  = rd_gnt ? s1_axil_rready  : s0_axil_rready;

   assign m_axil_araddr  = rd_gnt ? s1_axil_araddr : s0_axil_araddr;
   assign m_axil_arprot  = rd_gnt ? s1_axil_arprot : s0_axil_arprot;
   assign m_axil_arvalid = rd_addr & g_arvalid;
   assign m_axil_rready  = rd_data & g_rready;

   assign ar_rdy = rd_addr & m_axil_arready;
   assign r_vld  = rd_data & m_axil_rvalid;
   assign s0_axil_arready = ar_rdy & ~rd_gnt;
   assign s1_axil_arready = ar_rdy & rd_gnt;
   assign s0_axil_rvalid  = r_vld & ~rd_gnt;
   assign s1_axil_rvalid  = r_vld & rd_gnt;
   assign s0_axil_rdata   = m_axil_rdata;
   assign s1_axil_rdata   = m_axil_rdata;
   assign s0_axil_rresp   = m_axil_rresp;
   assign s1_axil_rresp   = m_axil_rresp;

   assign ar_hs = m_axil_arvalid & m_axil_arready;
   assign r_hs  = m_axil_rvalid & m_axil_rready;

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (rd_req) rd_next = RD_ADDR;
         RD_ADDR: if (ar_hs) rd_next = RD_DATA;
         RD_DATA: if (r_hs) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         rd_gnt   <= 1'b0;
      end else begin
         rd_state <= rd_next;
         if (rd_state == RD_IDLE && rd_req) rd_gnt <= rd_pick;
      end
   end

endmodule

// File: tb/tb_axil_arb_2to1.sv
// Directed bench for axil_arb_2to1: table-driven single writes and tie reads,
// plus hand sequences for reset, W-before-AW, parallel paths and mid-response reset.
module tb_axil_arb_2to1;

   logic        clk, rst_n;
   logic [31:0] s0_awaddr, s1_awaddr, s0_wdata, s1_wdata, s0_araddr, s1_araddr;
   logic [2:0]  s0_awprot, s1_awprot, s0_arprot, s1_arprot;
   logic [3:0]  s0_wstrb, s1_wstrb;
   logic        s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_bready, s1_bready;
   logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready;
   logic        s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
   logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid;
   logic [1:0]  s0_bresp, s1_bresp, s0_rresp, s1_rresp;
   logic [31:0] s0_rdata, s1_rdata;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0]  m_bresp, m_rresp;

   int total = 0;
   int bad   = 0;

   axil_arb_2to1 dut (
      .clk(clk), .rst_n(rst_n),
      .s0_axil_awaddr(s0_awaddr), .s0_axil_awprot(s0_awprot), .s0_axil_awvalid(s0_awvalid),
      .s0_axil_awready(s0_awready), .s0_axil_wdata(s0_wdata), .s0_axil_wstrb(s0_wstrb),
      .s0_axil_wvalid(s0_wvalid), .s0_axil_wready(s0_wready), .s0_axil_bresp(s0_bresp),
      .s0_axil_bvalid(s0_bvalid), .s0_axil_bready(s0_bready), .s0_axil_araddr(s0_araddr),
      .s0_axil_arprot(s0_arprot), .s0_axil_arvalid(s0_arvalid), .s0_axil_arready(s0_arready),
      .s0_axil_rdata(s0_rdata), .s0_axil_rresp(s0_rresp), .s0_axil_rvalid(s0_rvalid),
      .s0_axil_rready(s0_rready),
      .s1_axil_awaddr(s1_awaddr), .s1_axil_awprot(s1_awprot), .s1_axil_awvalid(s1_awvalid),
      .s1_axil_awready(s1_awready), .s1_axil_wdata(s1_wdata), .s1_axil_wstrb(s1_wstrb),
      .s1_axil_wvalid(s1_wvalid), .s1_axil_wready(s1_wready), .s1_axil_bresp(s1_bresp),
      .s1_axil_bvalid(s1_bvalid), .s1_axil_bready(s1_bready), .s1_axil_araddr(s1_araddr),
      .s1_axil_arprot(s1_arprot), .s1_axil_arvalid(s1_arvalid), .s1_axil_arready(s1_arready),
      .s1_axil_rdata(s1_rdata), .s1_axil_rresp(s1_rresp), .s1_axil_rvalid(s1_rvalid),
      .s1_axil_rready(s1_rready),
      .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
      .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
      .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
      .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .m_axil_araddr(m_araddr),
      .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
      .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
      .m_axil_rready(m_rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      bit          port;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] exp_awaddr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
      logic [1:0]  exp_bresp;
   } wvec_t;

   typedef struct {
      logic [31:0] exp_addr;
      bit          exp_port;
   } rvec_t;

   wvec_t wv[4];
   rvec_t rv[3];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      {s0_awaddr, s1_awaddr, s0_wdata, s1_wdata, s0_araddr, s1_araddr} = '0;
      {s0_awprot, s1_awprot, s0_arprot, s1_arprot, s0_wstrb, s1_wstrb} = '0;
      {s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_bready, s1_bready} = '0;
      {s0_arvalid, s1_arvalid, s0_rready, s1_rready} = '0;
      {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_bresp, m_rresp, m_rdata} = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
   endtask

   task automatic wr_txn(input wvec_t v);
      if (v.port) begin
         s1_awaddr = v.addr; s1_wdata = v.data; s1_wstrb = v.strb;
         s1_awvalid = 1; s1_wvalid = 1;
         s0_awaddr = 32'hBAD0BAD0; s0_wdata = 32'h0; s0_wstrb = 4'h0;
      end else begin
         s0_awaddr = v.addr; s0_wdata = v.data; s0_wstrb = v.strb;
         s0_awvalid = 1; s0_wvalid = 1;
         s1_awaddr = 32'hBAD0BAD0; s1_wdata = 32'h0; s1_wstrb = 4'h0;
      end
      s0_bready = 1; s1_bready = 1;
      m_awready = 1; m_wready = 1; m_bvalid = 0;
      step();
      chk("wr_m_valids", {m_awvalid, m_wvalid}, 2'b11);
      chk("wr_awaddr", m_awaddr, v.exp_awaddr);
      chk("wr_wdata", m_wdata, v.exp_wdata);
      chk("wr_wstrb", m_wstrb, v.exp_wstrb);
      chk("wr_awready_route", {s1_awready, s0_awready}, v.port ? 2'b10 : 2'b01);
      chk("wr_wready_route", {s1_wready, s0_wready}, v.port ? 2'b10 : 2'b01);
      step();
      {s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid} = '0;
      m_bvalid = 1; m_bresp = v.resp;
      #1;
      chk("wr_bvalid_route", {s1_bvalid, s0_bvalid}, v.port ? 2'b10 : 2'b01);
      chk("wr_bresp", v.port ? s1_bresp : s0_bresp, v.exp_bresp);
      chk("wr_bready_m", {m_bready, m_awvalid, m_wvalid}, 3'b100);
      step();
      m_bvalid = 0;
      #1;
      chk("wr_after_resp", {s1_bvalid, s0_bvalid, m_bready}, 3'b000);
      m_awready = 0; m_wready = 0;
   endtask

   initial begin
      int n, wr_p, awh, wh, prem, in_resp, stall_ok;

      wv[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00};
      wv[1] = '{1, 32'h0000_0020, 32'h1234_5678, 4'h3, 2'b10, 32'h0000_0020, 32'h1234_5678, 4'h3, 2'b10};
      wv[2] = '{0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 2'b01};
      wv[3] = '{1, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'b11, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'b11};
`ifdef AXIL_ARB_FIXED_PRIO_EN
      rv[0] = '{32'h100, 0}; rv[1] = '{32'h100, 0}; rv[2] = '{32'h100, 0};
`else
      rv[0] = '{32'h100, 0}; rv[1] = '{32'h200, 1}; rv[2] = '{32'h100, 0};
`endif

      // reset with s0 read pending and master side pushing valids/readies
      idle_inputs();
      rst_n = 1'b0;
      s0_araddr = 32'h44; s0_arvalid = 1;
      m_awready = 1; m_wready = 1; m_bvalid = 1; m_rvalid = 1;
      s0_bready = 1; s1_bready = 1; s0_rready = 1; s1_rready = 1;
      step(); step();
      chk("reset_outputs_zero",
          {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
           s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid,
           s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid}, 15'h0);
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_rvalid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(); step();
      chk("reset_release_arvalid", m_arvalid, 1'b1);
      chk("reset_release_araddr", m_araddr, 32'h44);

      // table-driven single writes
      do_reset();
      for (int i = 0; i < 4; i++) wr_txn(wv[i]);

      // both ports reading continuously
      do_reset();
      s0_araddr = 32'h100; s1_araddr = 32'h200;
      s0_arvalid = 1; s1_arvalid = 1; s0_rready = 1; s1_rready = 1;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (!m_arvalid && n < 5) begin step(); n++; end
         chk("rd_arvalid", m_arvalid, 1'b1);
         chk("rd_araddr_order", m_araddr, rv[i].exp_addr);
         m_arready = 1;
         #1;
         chk("rd_arready_route", {s1_arready, s0_arready}, rv[i].exp_port ? 2'b10 : 2'b01);
         step();
         m_arready = 0; m_rvalid = 1; m_rresp = 2'b00;
         m_rdata = rv[i].exp_addr ^ 32'hA5A5_0000;
         #1;
         chk("rd_rvalid_route", {s1_rvalid, s0_rvalid}, rv[i].exp_port ? 2'b10 : 2'b01);
         chk("rd_rdata", rv[i].exp_port ? s1_rdata : s0_rdata, rv[i].exp_addr ^ 32'hA5A5_0000);
         step();
         m_rvalid = 0;
      end

      // W three cycles before AW, AW accept delayed
      do_reset();
      s1_awaddr = 32'h300; s1_wdata = 32'hCAFE_F00D; s1_wstrb = 4'hF;
      s1_wvalid = 1; s1_bready = 1; m_wready = 1; m_awready = 0;
      wr_p = 0; awh = 0; wh = 0; prem = 0; in_resp = 0;
      for (int c = 0; c < 20 && in_resp == 0; c++) begin
         if (c == 3) s1_awvalid = 1;
         if (c == 8) m_awready = 1;
         #1;
         if (m_bready && !(awh > 0 && wh > 0)) prem++;
         if (m_bready) in_resp = 1;
         else begin
            if (s1_wready) wr_p++;
            if (m_awvalid && m_awready) begin
               awh++;
               chk("w_first_awaddr", m_awaddr, 32'h300);
            end
            if (m_wvalid && m_wready) wh++;
            step();
         end
      end
      chk("w_first_resp_reached", in_resp, 1);
      chk("w_first_wready_pulses", wr_p, 1);
      chk("w_first_aw_hs", awh, 1);
      chk("w_first_w_hs", wh, 1);
      chk("w_first_premature_resp", prem, 0);
      {s1_awvalid, s1_wvalid, m_awready, m_wready} = '0;
      m_bvalid = 1;
      #1;
      chk("w_first_bvalid_route", {s1_bvalid, s0_bvalid}, 2'b10);
      step();
      m_bvalid = 0;

      // concurrent write (s0) and read (s1), write response stalled
      do_reset();
      s0_awaddr = 32'h40; s0_wdata = 32'h55; s0_wstrb = 4'hF;
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 0;
      s1_araddr = 32'h80; s1_arvalid = 1; s1_rready = 1;
      m_awready = 1; m_wready = 1; m_arready = 1;
      step();
      chk("par_valids", {m_awvalid, m_wvalid, m_arvalid, m_araddr}, {3'b111, 32'h80});
      step();
      {s0_awvalid, s0_wvalid, s1_arvalid, m_awready, m_wready, m_arready} = '0;
      m_bvalid = 1; m_rvalid = 1; m_rdata = 32'h1234;
      #1;
      chk("par_ready_split", {m_bready, m_rready, s1_rvalid}, 3'b011);
      chk("par_rdata", s1_rdata, 32'h1234);
      step();
      m_rvalid = 0;
      stall_ok = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (s0_bvalid && !m_bready && !m_rready) stall_ok++;
         step();
      end
      chk("par_write_stalled", stall_ok, 10);
      s0_bready = 1;
      #1;
      chk("par_bready_release", m_bready, 1'b1);
      step();
      m_bvalid = 0;
      #1;
      chk("par_write_done", {s0_bvalid, m_bready}, 2'b00);

      // reset while a write response is pending
      do_reset();
      s0_awaddr = 32'h70; s0_wdata = 32'h77; s0_wstrb = 4'hF;
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 0;
      m_awready = 1; m_wready = 1;
      step(); step();
      {s0_awvalid, s0_wvalid, m_awready, m_wready} = '0;
      m_bvalid = 1;
      #1;
      chk("rst_resp_pending", s0_bvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_resp_dropped", {s0_bvalid, m_bready}, 2'b00);
      m_bvalid = 0;
      step();
      rst_n = 1'b1;
      s0_awaddr = 32'h500; s1_awaddr = 32'h600;
      {s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid} = 4'b1111;
      step();
      chk("rst_regrant_awaddr", {m_awvalid, m_awaddr}, {1'b1, 32'h500});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
